idea_round_sequencer: RTL

IDEA_ROUND_SEQUENCER -- requirements
Module: idea_round_sequencer

---
 rtl/idea_round_sequencer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/idea_round_sequencer.sv
`default_nettype none
// idea_round_sequencer: steps an external IDEA round unit through 8 rounds plus the output transform (rev 1.0)
module idea_round_sequencer (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic [127:0] K,
  input  logic [63:0]  X,
  output logic         BUSY,
  output logic         DONE,
  output logic [63:0]  X_OUT,
  output logic [63:0]  RND_IN,
  output logic [95:0]  RND_Z,
  output logic         RND_FINAL,
  input  logic [63:0]  RND_OUT
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [3:0] LAST_RND = 4'd8;

  state_t         state_q, state_d;
  logic [3:0]     rnd_q, rnd_d;
  logic [2:0]     off_q, off_d;
  logic [63:0]    data_q, data_d;
  logic [127:0]   ka_q, ka_d;
  logic [127:0]   kb_q, kb_d;
  logic           done_q, done_d;
  logic [63:0]    x_out_q, x_out_d;
  logic [3:0]     off_next;
  logic [3:0]     off_wrap;
  logic [191:0]   key_window;
  logic [7:0]     z_msb;

  function automatic logic [127:0] rotl25(input logic [127:0] v);
    return {v[102:0], v[127:103]};
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      rnd_q   <= 4'd0;
      off_q   <= 3'd0;
      data_q  <= 64'd0;
      ka_q    <= 128'd0;
      kb_q    <= 128'd0;
      done_q  <= 1'b0;
      x_out_q <= 64'd0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      off_q   <= off_d;
      data_q  <= data_d;
      ka_q    <= ka_d;
      kb_q    <= kb_d;
      done_q  <= done_d;
      x_out_q <= x_out_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rnd_d    = rnd_q;
    off_d    = off_q;
    data_d   = data_q;
    ka_d     = ka_q;
    kb_d     = kb_q;
    done_d   = 1'b0;
    x_out_d  = x_out_q;
    off_next = {1'b0, off_q} + 4'd6;
    off_wrap = off_next - 4'd8;

    case (state_q)
      IDLE: begin
        if (START) begin
          state_d = RUN;
          data_d  = X;
          ka_d    = K;
          kb_d    = rotl25(K);
          off_d   = 3'd0;
          rnd_d   = 4'd0;
        end
      end
      RUN: begin
        if (rnd_q == LAST_RND) begin
          x_out_d = RND_OUT;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          data_d = RND_OUT;
          rnd_d  = rnd_q + 4'd1;
          // Window runs past KA: slide the key pair forward by one rotation.
          if (off_next >= 4'd8) begin
            off_d = off_wrap[2:0];
            ka_d  = kb_q;
            kb_d  = rotl25(kb_q);
          end else begin
            off_d = off_next[2:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Offset never exceeds 6, so the window never reaches KB words 4..7.
  assign key_window = {ka_q, kb_q[127:64]};
  assign z_msb      = 8'd191 - {1'b0, off_q, 4'b0000};

  assign BUSY      = (state_q == RUN);
  assign DONE      = done_q;
  assign X_OUT     = x_out_q;
  assign RND_IN    = (state_q == RUN) ? data_q : 64'd0;
  assign RND_Z     = (state_q == RUN) ? key_window[z_msb -: 96] : 96'd0;
  assign RND_FINAL = (state_q == RUN) && (rnd_q == LAST_RND);

endmodule
`default_nettype wire
